// File: rtl/instruction_fetcher.sv
// instruction_fetcher: PC tracking, one-outstanding word fetch and an instruction queue feeding the decoder.
// Optional IF_JAL_PREDICT_EN: steer fetch to the target of JAL words using their J-immediate.
module instruction_fetcher #(
  parameter int          QUEUE_DEPTH_LOG = 3,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_inst,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic [1:0]  dbg_state
);
  // Handshakes: the decoder side pops when inst_valid && inst_ready on a cycle
  // with rdy=1 and no flush; the memory side holds mem_req/mem_addr as a level
  // until the single mem_valid strobe answers it.

  localparam int DEPTH = 1 << QUEUE_DEPTH_LOG;
  localparam int FW    = QUEUE_DEPTH_LOG + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t                     state;
  state_t                     state_next;
  logic [31:0]                pc;
  logic [31:0]                next_pc;
  logic [31:0]                q_inst [DEPTH];
  logic [31:0]                q_pc   [DEPTH];
  logic [QUEUE_DEPTH_LOG-1:0] head;
  logic [QUEUE_DEPTH_LOG-1:0] tail;
  logic [QUEUE_DEPTH_LOG:0]   count;
  logic                       push;
  logic                       pop;
  logic                       space;
  logic [FW-1:0]              fill_next;
  logic                       req_next;
  logic [31:0]                addr_next;

  assign inst_valid = (count != '0);
  assign inst_out   = q_inst[head];
  assign inst_pc    = q_pc[head];
  assign dbg_state  = state;

  assign push      = rdy && !flush && (state == S_WAIT) && mem_valid;
  assign pop       = rdy && !flush && inst_valid && inst_ready;
  assign fill_next = {1'b0, count} + FW'(push) - FW'(pop);
  assign space     = fill_next < FW'(DEPTH);

`ifdef IF_JAL_PREDICT_EN
  logic [31:0] j_imm;
  assign j_imm   = {{12{mem_inst[31]}}, mem_inst[19:12], mem_inst[20], mem_inst[30:21], 1'b0};
  assign next_pc = (mem_inst[6:0] == 7'b1101111) ? pc + j_imm : pc + 32'd4;
`else
  assign next_pc = pc + 32'd4;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else if (rdy) begin
      state <= state_next;
    end
  end

  // A flush never cancels a request already on the bus: it is drained in DROP.
  always_comb begin
    state_next = state;
    if (flush) begin
      case (state)
        S_WAIT:  state_next = mem_valid ? S_IDLE : S_DROP;
        S_DROP:  state_next = mem_valid ? S_IDLE : S_DROP;
        default: state_next = S_IDLE;
      endcase
    end else begin
      case (state)
        S_IDLE:  if (space) state_next = S_WAIT;
        S_WAIT:  if (mem_valid && !space) state_next = S_IDLE;
        S_DROP:  if (mem_valid) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_next  = mem_req;
    addr_next = mem_addr;
    if (state_next == S_IDLE) begin
      req_next = 1'b0;
    end else if (!flush && state == S_IDLE) begin
      req_next  = 1'b1;
      addr_next = pc;
    end else if (!flush && state == S_WAIT && mem_valid) begin
      req_next  = 1'b1;
      addr_next = next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (rdy) begin
      mem_req  <= req_next;
      mem_addr <= addr_next;
      if (flush) begin
        pc    <= flush_pc;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) pc <= next_pc;
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        count <= fill_next[QUEUE_DEPTH_LOG:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[tail] <= mem_inst;
      q_pc[tail]   <= pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Randomized bench for instruction_fetcher: a behavioural memory plus a queue-level model of
// which {inst, pc} entries the decoder must see and which address each live fetch must use.
module tb_instruction_fetcher;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_inst;
  logic        flush;
  logic [31:0] flush_pc;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instruction_fetcher #(.QUEUE_DEPTH_LOG(3), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_inst(mem_inst),
    .flush(flush), .flush_pc(flush_pc),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .dbg_state(dbg_state)
  );

  // Reference state: entries are {inst, pc}.
  logic [63:0] exp_q[$];
  logic [31:0] exp_fetch;
  logic [31:0] req_a;
  logic [31:0] last_req_a;
  logic [31:0] second_req;
  logic        outstanding;
  logic        stale;
  logic        expect_req;
  logic        resp_flushed;
  int          delay;
  int          min_dly;
  int          max_dly;
  int          n_req;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    if (a == 32'h0) return 32'h0080006F;
    h = a * 32'h9E3779B1 + 32'h7F4A7C15;
    if (a >= 32'h1000 && a[4:2] == 3'd5) h[6:0] = 7'h6F;
    else if (h[6:0] == 7'h6F) h[0] = 1'b0;
    return h;
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] a, input logic [31:0] w);
`ifdef IF_JAL_PREDICT_EN
    int imm;
    if (w[6:0] == 7'h6F) begin
      imm = {w[31], w[19:12], w[20], w[30:21]};
      imm = imm * 2;
      if (w[31]) imm = imm - (1 << 21);
      return a + 32'(imm);
    end
`endif
    return a + 32'd4;
  endfunction

  // One clock cycle: check outputs, act as memory, drive inputs, advance the model.
  task automatic cycle(input logic r_rdy, input logic r_ready, input logic r_flush,
                       input logic [31:0] r_fpc, input logic flush_on_resp);
    logic mv;
    logic fl;
    @(negedge clk);
    if (expect_req) check("issue", mem_req, 1);
    check("inst_valid", inst_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("head_inst", inst_out, exp_q[0][63:32]);
      check("head_pc", inst_pc, exp_q[0][31:0]);
    end
    if (mem_req && !outstanding) begin
      check("req_addr", mem_addr, exp_fetch);
      check("req_space", exp_q.size() < 8, 1);
      outstanding = 1'b1;
      stale       = 1'b0;
      req_a       = mem_addr;
      last_req_a  = mem_addr;
      n_req++;
      if (n_req == 2) second_req = mem_addr;
      delay = $urandom_range(min_dly, max_dly);
    end else if (outstanding) begin
      check("req_hold", {mem_req, mem_addr}, {1'b1, req_a});
    end
    mv = outstanding && r_rdy && delay == 0;
    if (outstanding && r_rdy && delay > 0) delay--;
    fl = r_flush || (flush_on_resp && mv);
    if (flush_on_resp && mv && r_rdy) resp_flushed = 1'b1;
    rdy        = r_rdy;
    mem_valid  = mv;
    mem_inst   = mv ? mem_word(req_a) : $urandom;
    flush      = fl;
    flush_pc   = r_fpc;
    inst_ready = r_ready;
    expect_req = 1'b0;
    if (r_rdy) begin
      expect_req = !mem_req && exp_q.size() < 8 && !fl;
      if (exp_q.size() != 0 && r_ready && !fl) void'(exp_q.pop_front());
      if (mv) begin
        outstanding = 1'b0;
        if (!fl && !stale) begin
          exp_q.push_back({mem_word(req_a), req_a});
          exp_fetch = ref_next(req_a, mem_word(req_a));
        end
      end
      if (fl) begin
        exp_q.delete();
        exp_fetch = r_fpc;
        if (outstanding) stale = 1'b1;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n0;
    int rp;
    logic r_rdy;
    logic r_ready;
    logic r_fl;
    logic [31:0] r_fpc;

    rst = 1'b1; rdy = 1'b1; mem_valid = 1'b0; mem_inst = '0;
    flush = 1'b0; flush_pc = '0; inst_ready = 1'b0;
    outstanding = 1'b0; stale = 1'b0; delay = 0; n_req = 0;
    resp_flushed = 1'b0; second_req = '0; last_req_a = '0; req_a = '0;
    min_dly = 2; max_dly = 2;
    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, RESET_PC);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_state", dbg_state, 0);
    rst        = 1'b0;
    exp_fetch  = RESET_PC;
    expect_req = 1'b1;

    // Fill the queue with no consumer, then release exactly one entry.
    for (int i = 0; i < 60; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("full_no_req", mem_req, 0);
    check("full_head_pc", inst_pc, RESET_PC);
`ifdef IF_JAL_PREDICT_EN
    check("jal_second_req", second_req, 32'h8);
`else
    check("jal_second_req", second_req, 32'h4);
`endif
    n0 = n_req;
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    k = 0;
    while (n_req == n0 && k < 10) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      k++;
    end
`ifdef IF_JAL_PREDICT_EN
    check("refill_addr", last_req_a, 32'h24);
`else
    check("refill_addr", last_req_a, 32'h20);
`endif

    // Flush while a request is waiting for its response.
    min_dly = 3; max_dly = 3;
    k = 0;
    while (!(outstanding && delay > 0) && k < 40) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      k++;
    end
    check("wait_for_req", outstanding && delay > 0, 1);
    cycle(1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
    n0 = n_req;
    k = 0;
    while (n_req == n0 && k < 30) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      k++;
    end
    check("flush_addr", last_req_a, 32'h100);
    k = 0;
    while (!inst_valid && k < 20) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      k++;
    end
    check("flush_first_pc", {inst_valid, inst_pc}, {1'b1, 32'h100});

    // Flush in the same cycle as a response.
    min_dly = 1; max_dly = 2;
    k = 0;
    while (!resp_flushed && k < 30) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h200, 1'b1);
      k++;
    end
    check("resp_flush_seen", resp_flushed, 1);
    n0 = n_req;
    k = 0;
    while (n_req == n0 && k < 10) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      k++;
    end
    check("resp_flush_addr", last_req_a, 32'h200);

    // Random traffic in blocks with differing consumer pressure.
    for (int b = 0; b < 16; b++) begin
      case (b % 4)
        0:       rp = 0;
        1:       rp = 30;
        2:       rp = 70;
        default: rp = 100;
      endcase
      min_dly = 0;
      max_dly = $urandom_range(0, 3);
      for (int i = 0; i < 200; i++) begin
        r_rdy   = $urandom_range(0, 9) != 0;
        r_ready = $urandom_range(0, 99) < rp;
        r_fl    = $urandom_range(0, 49) == 0;
        r_fpc   = 32'($urandom_range(0, 32'h3FFF)) << 2;
        cycle(r_rdy, r_ready, r_fl, r_fpc, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
